// File: rtl/uart_rx_ctrl.sv
// UART receive-side word packer: gathers eight received bytes (LSB byte first) into
// a 64-bit word and writes each word to memory at consecutive addresses per armed session.
module uart_rx_ctrl #(
  parameter int unsigned WORDS     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button,
  input  logic        rxDone,
  input  logic        rxErr,
  input  logic [7:0]  data_rx,
  output logic [63:0] data_out,
  output logic [15:0] data_addr,
  output logic        memwrite,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] LAST_WORD = 16'(WORDS - 32'd1);

  state_e      state_q, state_d;
  logic        btn_q;
  logic [63:0] shift_q, shift_d;
  logic [63:0] data_out_q, data_out_d;
  logic [15:0] data_addr_q, data_addr_d;
  logic        memwrite_q, memwrite_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        start_s;
  logic        accept_s;
  logic        drop_s;
  logic [5:0]  byte_lsb_s;

  // Falling edge of the idle-high button arms a session.
  assign start_s    = btn_q & ~button;
  assign accept_s   = (state_q == ST_RECV) & rxDone & ~rxErr;
  assign drop_s     = (state_q == ST_RECV) & rxDone & rxErr;
  assign byte_lsb_s = {byte_cnt_q, 3'b000};

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    data_addr_d = data_addr_q;
    memwrite_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_d     = ST_RECV;
          data_addr_d = BASE_ADDR;
          byte_cnt_d  = 3'd0;
          word_cnt_d  = 16'd0;
          err_d       = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_RECV: begin
        if (accept_s) begin
          shift_d[byte_lsb_s +: 8] = data_rx;
          byte_cnt_d               = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            // The eighth byte goes straight to the output; the shift copy is stale after this.
            data_out_d = {data_rx, shift_q[55:0]};
            memwrite_d = 1'b1;
          end else begin
            memwrite_d = 1'b0;
          end
        end else if (drop_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end

        // Address advances only once the write strobe has been seen by memory.
        if (memwrite_q) begin
          data_addr_d = data_addr_q + 16'd1;
          word_cnt_d  = word_cnt_q + 16'd1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b1;
      shift_q     <= 64'd0;
      data_out_q  <= 64'd0;
      data_addr_q <= BASE_ADDR;
      memwrite_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_cnt_q  <= 3'd0;
      word_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      btn_q       <= button;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      data_addr_q <= data_addr_d;
      memwrite_q  <= memwrite_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign data_addr = data_addr_q;
  assign memwrite  = memwrite_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side companion to the UART transmit controller. It accepts bytes from the UART receiver, one per rxDone pulse, and packs 8 bytes into a 64-bit word, LSB byte first. It then writes each word to data memory at consecutive addresses. Capture is armed by the active-low push button and stops after a fixed number of words.

Parameters:
WORDS, 4, number of 64-bit words captured per armed session (1..65535)
BASE_ADDR, 16'h0000, first memory word address written each session

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
button  input  1  start button, active-low, idle high, already debounced and synchronous to clk
rxDone  input  1  one-cycle pulse from UART receiver: data_rx valid this cycle
rxErr  input  1  framing error flag from receiver, qualified by rxDone
data_rx  input  8  received byte
data_out  output  64  assembled word to memory
data_addr  output  16  memory word address
memwrite  output  1  one-cycle memory write strobe
busy  output  1  high while session active (RECV state)
done  output  1  high in DONE state until next start
err  output  1  sticky: at least one byte dropped for framing error this session

Behaviour:
- Reset (async, rst_n=0): state=IDLE, data_out=0, data_addr=BASE_ADDR, memwrite=0, busy=0, done=0, err=0, byte_cnt=0, word_cnt=0, shift register=0. Release is synchronous to the next clk edge.
- Start detect: register button; start = previous 1 and current 0 (falling edge). It is a single-cycle event and is ignored unless state is IDLE or DONE.
- States:
  - IDLE: wait for start.
  - RECV: assemble bytes.
  - DONE: session complete.
- IDLE/DONE -> RECV on start. On that edge: data_addr=BASE_ADDR, byte_cnt=0, word_cnt=0, err=0, done=0, busy=1.
- RECV byte accept: rxDone=1 and rxErr=0. The byte is stored at bits [8*byte_cnt+7 : 8*byte_cnt], so the first byte lands in [7:0] and the eighth in [63:56]. byte_cnt then increments mod 8.
- rxDone=1 with rxErr=1: byte discarded, byte_cnt unchanged, err<=1.
- Word completion: on the edge accepting the 8th byte, data_out<=full assembled word. memwrite=1 for exactly the following cycle, with data_addr unchanged during that cycle. On the edge ending the memwrite cycle, data_addr<=data_addr+1 (16-bit wrap, FFFF->0000) and word_cnt increments.
- Write latency: 8th rxDone sampled at edge N -> memwrite high from edge N to edge N+1.
- Back-to-back bytes: a byte arriving during the memwrite cycle is accepted as byte 0 of the next word. data_out does not change during memwrite.
- Session end: when the memwrite for word WORDS-1 completes, the state goes RECV->DONE on that same edge. At that edge busy=0 and done=1. data_addr ends at BASE_ADDR+WORDS.
- Ignored inputs:
  - rxDone in IDLE/DONE: no effect on any output.
  - start during RECV: no effect.
- Partial word: bytes remain held in the shift register indefinitely; there is no timeout.
- Reset mid-session: everything returns to reset values and the partial word is lost. No memwrite is issued during or after reset.
- Restart from DONE: err, done, and counters are cleared. The shift register need not be cleared because every word is fully overwritten.

Test Plan:
1. Reset, then press button (1->0 for one cycle), then send bytes 01..08 via rxDone pulses 120 ns apart -> exactly one memwrite with data_out=64'h0807060504030201 at data_addr=0000; data_addr=0001 afterwards; busy=1.
2. WORDS=4: send 32 bytes 01..20 -> four memwrites at addresses 0000..0003 with words 0807060504030201, 100F0E0D0C0B0A09, 1817161514131211, 201F1E1D1C1B1A19; then done=1, busy=0. A further rxDone produces no memwrite.
3. Send 3 bytes with rxErr=1 interleaved among 8 good bytes AA..B1 -> err=1 and a single word 64'hB1B0AFAEADACABAA; the dropped bytes are absent.
4. Send 8 bytes 11..18, then pulse rxDone with 0x99 in the memwrite cycle, then 7 more bytes 9A..A0 -> second word = 64'hA09F9E9D9C9B9A99. Both memwrites appear; the first word is unchanged.
5. rxDone pulses before any button press -> no memwrite, busy=0. Press button during RECV -> counters and address unaffected.
6. Assert rst_n=0 after 5 bytes of word 1, then release and re-arm with 8 bytes -> the first memwrite is at BASE_ADDR with only the new bytes. All outputs are at reset values while rst_n=0.
